// File: rtl/lane_add_node_ctrl.sv
// rtl/lane_add_node_ctrl.sv - add-node lane sequencer: gene issue, split selection, node-ID counter, result serializer
module lane_add_node_ctrl #(
    parameter int                 GENE_SZ     = 64,
    parameter int                 ATTR_SZ     = 8,
    parameter logic [ATTR_SZ-1:0] HIDDEN_BASE = 8'd16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ATTR_SZ-1:0] gene_count,
    input  logic [ATTR_SZ-1:0] target_idx,
    input  logic [ATTR_SZ-1:0] genome_id_in,
    input  logic               cnt_load,
    input  logic [ATTR_SZ-1:0] cnt_load_val,
    input  logic [GENE_SZ-1:0] in_gene,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [1:0]         lane_state,
    output logic [GENE_SZ-1:0] lane_gene,
    output logic [ATTR_SZ-1:0] lane_genome_id,
    output logic [ATTR_SZ-1:0] node_id_max,
    input  logic [GENE_SZ-1:0] lane_gene1,
    input  logic [GENE_SZ-1:0] lane_gene2,
    input  logic [GENE_SZ-1:0] lane_gene3,
    input  logic [2:0]         lane_valid,
    output logic [GENE_SZ-1:0] out_gene,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               busy,
    output logic               done,
    output logic               node_added,
    output logic               cnt_sat
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [ATTR_SZ-1:0] ONE = {{(ATTR_SZ-1){1'b0}}, 1'b1};
    localparam logic [1:0] LS_PASS   = 2'b00;
    localparam logic [1:0] LS_MUTATE = 2'b10;
    localparam logic [1:0] LS_IDLE   = 2'b01;

    state_t r_state;
    state_t w_next;

    logic [ATTR_SZ-1:0] r_count;
    logic [ATTR_SZ-1:0] r_target;
    logic [ATTR_SZ-1:0] r_genome_id;
    logic [ATTR_SZ-1:0] r_idx;
    logic [ATTR_SZ-1:0] r_cnt;
    logic               r_node_added;
    logic               r_added_pend;

    logic               r_iss_vld;
    logic [1:0]         r_lane_state;
    logic [GENE_SZ-1:0] r_lane_gene;
    logic               r_iss_last;

    logic               r_pend;
    logic [GENE_SZ-1:0] r_pend_gene;
    logic               r_pend_last;

    logic [GENE_SZ-1:0] r_slot0;
    logic [GENE_SZ-1:0] r_slot1;
    logic [GENE_SZ-1:0] r_slot2;
    logic [2:0]         r_mask;
    logic               r_ser_last;

    logic [GENE_SZ-1:0] w_head_gene;
    logic [2:0]         w_rest;
    logic               w_out_valid;
    logic               w_out_fire;
    logic               w_ser_free;
    logic               w_in_ready;
    logic               w_in_fire;
    logic               w_final_fire;
    logic               w_cnt_sat;
    logic               w_mutate;

    // Serializer head is the lowest pending slot; w_rest is what remains after it leaves.
    always_comb begin
        w_head_gene = '0;
        w_rest      = 3'b000;
        if (r_mask[0]) begin
            w_head_gene = r_slot0;
            w_rest      = r_mask & 3'b110;
        end else if (r_mask[1]) begin
            w_head_gene = r_slot1;
            w_rest      = r_mask & 3'b100;
        end else if (r_mask[2]) begin
            w_head_gene = r_slot2;
            w_rest      = 3'b000;
        end
    end

    assign w_cnt_sat   = (r_cnt == {ATTR_SZ{1'b1}});
    assign w_out_valid = |r_mask;
    assign w_out_fire  = w_out_valid & out_ready;
    // Accepting while the final slot drains keeps a pass gene at 3 cycles accept-to-accept.
    assign w_ser_free  = !w_out_valid | (w_out_fire & (w_rest == 3'b000));
    assign w_in_ready  = (r_state == S_RUN) & !r_iss_vld & !r_pend & w_ser_free & (r_idx < r_count);
    assign w_in_fire   = in_valid & w_in_ready;
    assign w_final_fire = w_out_fire & (w_rest == 3'b000) & r_ser_last;
    assign w_mutate    = (r_idx == r_target) & !w_cnt_sat;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (gene_count == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_final_fire) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count      <= '0;
            r_target     <= '0;
            r_genome_id  <= '0;
            r_idx        <= '0;
            r_node_added <= 1'b0;
            r_added_pend <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_count      <= gene_count;
                r_target     <= target_idx;
                r_genome_id  <= genome_id_in;
                r_idx        <= '0;
                r_node_added <= 1'b0;
                r_added_pend <= 1'b0;
            end else begin
                if (w_in_fire) begin
                    r_idx <= r_idx + ONE;
                end
                if (r_pend && (lane_valid == 3'b111)) begin
                    r_added_pend <= 1'b1;
                end
                if (w_final_fire) begin
                    r_node_added <= r_added_pend;
                end
            end
        end
    end

    // Hidden-node counter saturates at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= HIDDEN_BASE;
        end else if ((r_state == S_IDLE) && cnt_load) begin
            r_cnt <= cnt_load_val;
        end else if (r_pend && (lane_valid == 3'b111) && !w_cnt_sat) begin
            r_cnt <= r_cnt + ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_iss_vld    <= 1'b0;
            r_lane_state <= LS_IDLE;
            r_lane_gene  <= '0;
            r_iss_last   <= 1'b0;
            r_pend       <= 1'b0;
            r_pend_gene  <= '0;
            r_pend_last  <= 1'b0;
        end else begin
            r_iss_vld <= w_in_fire;
            if (w_in_fire) begin
                r_lane_state <= w_mutate ? LS_MUTATE : LS_PASS;
                r_lane_gene  <= in_gene;
                r_iss_last   <= (r_idx == (r_count - ONE));
            end else begin
                r_lane_state <= LS_IDLE;
                r_lane_gene  <= '0;
                r_iss_last   <= 1'b0;
            end
            r_pend <= r_iss_vld;
            if (r_iss_vld) begin
                r_pend_gene <= r_lane_gene;
                r_pend_last <= r_iss_last;
            end
        end
    end

    // An empty lane mask is treated as a single pass-through of the issued gene.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot0    <= '0;
            r_slot1    <= '0;
            r_slot2    <= '0;
            r_mask     <= 3'b000;
            r_ser_last <= 1'b0;
        end else if (r_pend) begin
            r_ser_last <= r_pend_last;
            if (lane_valid == 3'b000) begin
                r_slot0 <= r_pend_gene;
                r_slot1 <= '0;
                r_slot2 <= '0;
                r_mask  <= 3'b001;
            end else begin
                r_slot0 <= lane_gene1;
                r_slot1 <= lane_gene2;
                r_slot2 <= lane_gene3;
                r_mask  <= lane_valid;
            end
        end else if (w_out_fire) begin
            r_mask <= w_rest;
        end
    end

    assign in_ready       = w_in_ready;
    assign lane_state     = r_lane_state;
    assign lane_gene      = r_lane_gene;
    assign lane_genome_id = r_genome_id;
    assign node_id_max    = r_cnt;
    assign out_gene       = w_head_gene;
    assign out_valid      = w_out_valid;
    assign out_last       = w_out_valid & (w_rest == 3'b000) & r_ser_last;
    assign busy           = (r_state != S_IDLE);
    assign done           = (r_state == S_DONE);
    assign node_added     = r_node_added;
    assign cnt_sat        = w_cnt_sat;

endmodule
